// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// The FSM, the op select and the counter all depend on these.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_t;

  localparam int ITERS = 32;
  localparam int CNT_W = 5;

endpackage

// File: rtl/multdiv_if.sv
// Operand/control/result bundle between the X stage and the multdiv unit.
// The master side issues operations and the slave side returns results.
interface multdiv_if #(
  parameter int W = 32
);
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic         ctrl_MULT;
  logic         ctrl_DIV;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  modport master (
    output data_operandA, data_operandB,
    output ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception,
    input  data_resultRDY, busy
  );

  modport slave (
    input  data_operandA, data_operandB,
    input  ctrl_MULT, ctrl_DIV,
    output data_result, data_exception,
    output data_resultRDY, busy
  );
endinterface

// File: rtl/multdiv_counter.sv
// Iteration counter: cleared on start, counts RUN cycles.
// The term output flags the final iteration.
module multdiv_counter
  import multdiv_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic term
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == CNT_W'(ITERS - 1));

endmodule

// File: rtl/multdiv_unit.sv
// Fixed-latency signed 32-bit multiply/divide unit for the X stage.
// Works on magnitudes and applies the sign when the result is registered.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_operandA,
  input  logic [DATA_WIDTH-1:0] data_operandB,
  input  logic                  ctrl_MULT,
  input  logic                  ctrl_DIV,
  output logic [DATA_WIDTH-1:0] data_result,
  output logic                  data_exception,
  output logic                  data_resultRDY,
  output logic                  busy
);

  localparam int W = DATA_WIDTH;

  state_t         state_q, state_d;
  op_t            op_q, op_d;
  logic           neg_q, neg_d;
  logic           dz_q, dz_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic [2*W:0]   work_q, work_d;
  logic [W-1:0]   res_q, res_d;
  logic           exc_q, exc_d;

  logic           start;
  logic           term;
  logic [W-1:0]   mag_a, mag_b;
  logic [W:0]     rem_s;
  logic [W+1:0]   add_s, sub_s;
  logic [2*W:0]   step;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quot;

  assign start = ctrl_MULT | ctrl_DIV;

  multdiv_counter u_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (start),
    .en    (state_q == RUN),
    .term  (term)
  );

  // |INT_MIN| wraps to 2^31, which is exact as an unsigned magnitude.
  always_comb begin
    mag_a = data_operandA[W-1] ? (~data_operandA + 1'b1)
                               : data_operandA;
    mag_b = data_operandB[W-1] ? (~data_operandB + 1'b1)
                               : data_operandB;
  end

  // Multiply keeps {acc, multiplier}; divide keeps {rem, quotient}.
  always_comb begin
    rem_s = {work_q[2*W-1:W], work_q[W-1]};
    sub_s = {1'b0, rem_s} - {2'b0, opnd_q};
    add_s = {1'b0, work_q[2*W:W]}
          + {2'b0, opnd_q & {W{work_q[0]}}};
    if (op_q == OP_MUL) begin
      step = {add_s, work_q[W-1:1]};
    end else if (sub_s[W+1]) begin
      step = {rem_s, work_q[W-2:0], 1'b0};
    end else begin
      step = {sub_s[W:0], work_q[W-2:0], 1'b1};
    end
    prod = neg_q ? (~step[2*W-1:0] + 1'b1) : step[2*W-1:0];
    quot = neg_q ? (~step[W-1:0] + 1'b1) : step[W-1:0];
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    opnd_d  = opnd_q;
    work_d  = work_q;
    res_d   = res_q;
    exc_d   = exc_q;
    if (start) begin
      state_d = RUN;
      op_d    = ctrl_MULT ? OP_MUL : OP_DIV;
      neg_d   = data_operandA[W-1] ^ data_operandB[W-1];
      dz_d    = (data_operandB == '0);
      opnd_d  = ctrl_MULT ? mag_a : mag_b;
      work_d  = {{(W+1){1'b0}}, ctrl_MULT ? mag_b : mag_a};
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          work_d = step;
          if (term) begin
            state_d = DONE;
            if (op_q == OP_MUL) begin
              res_d = prod[W-1:0];
              exc_d = ~(&prod[2*W-1:W-1] | ~|prod[2*W-1:W-1]);
            end else if (dz_q) begin
              res_d = '0;
              exc_d = 1'b1;
            end else begin
              res_d = quot;
              exc_d = ~neg_q & step[W-1];
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      opnd_q  <= '0;
      work_q  <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      opnd_q  <= opnd_d;
      work_q  <= work_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q == RUN);

endmodule
